// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer and its bench:
// state encoding, instruction width and proc opcode constants.
// The optional single-step feature is selected with FETCH_STEP_EN.
package fetch_pkg;

    // Instruction width; must equal the DIN width of proc.
    localparam int DW = 16;

    // Sequencer state encoding (legacy-compatible constants).
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_PAUSE = 3'd5;

    // proc opcodes (instruction bits [15:13]).
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Assemble an immediate-form proc instruction: op | imm=1 | rx | #imm9.
    function automatic logic [DW-1:0] asm_imm(input logic [2:0] op,
                                              input logic [2:0] rx,
                                              input logic [8:0] imm);
        return {op, 1'b1, rx, imm};
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM for the fetch sequencer: synchronous write, registered read.
// Contents are not reset; the program is loaded through the write port.
module prog_ram #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic          Clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Write port and registered read port share one clocked process.
    // NOTE: the array and read register have no reset so the RAM maps onto block memory.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction feeder for the 16-bit multicycle proc: holds a program RAM
// and a PC, issues each word on DIN with a one-cycle Run pulse, waits for
// Done, then advances. Define FETCH_STEP_EN to add the Step input and a
// PAUSE state that waits for a Step rising edge after every retire.
module instr_fetch_seq #(
    parameter int AW = 5,
    parameter int DW = fetch_pkg::DW
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          Stop,
    input  logic [AW-1:0] LastAddr,
    input  logic          ProgWr,
    input  logic [AW-1:0] ProgAddr,
    input  logic [DW-1:0] ProgData,
    input  logic          Done,
`ifdef FETCH_STEP_EN
    input  logic          Step,
`endif
    output logic [DW-1:0] DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Halted,
    output logic [AW-1:0] PC,
    output logic [15:0]   InstrCount
);

    import fetch_pkg::*;

    logic [2:0]    state, state_d;
    logic [AW-1:0] pc, pc_d;
    logic [AW-1:0] last_addr;
    logic [15:0]   instr_count;
    logic [DW-1:0] din;
    logic          run;
    logic          halted;
    logic          busy;
    logic          start_ok;
    logic          retire;
    logic          halt_entry;
    logic          step_rise;
    logic [DW-1:0] rd_data;

    assign busy       = (state == S_FETCH) || (state == S_ISSUE) ||
                        (state == S_WAIT)  || (state == S_PAUSE);
    assign start_ok   = Start && ((state == S_IDLE) || (state == S_HALT));
    assign retire     = (state == S_WAIT) && Done;
    assign halt_entry = (state_d == S_HALT) && (state != S_HALT);

`ifdef FETCH_STEP_EN
    logic step_q;

    // Remember the previous Step level so PAUSE reacts to a rising edge only.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            step_q <= 1'b0;
        end else begin
            step_q <= Step;
        end
    end

    assign step_rise = Step && !step_q;
`else
    assign step_rise = 1'b0;
`endif

    // Next state and next PC.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        case (state)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (Done) begin
                    if ((pc == last_addr) || Stop) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc + AW'(1);
`ifdef FETCH_STEP_EN
                        state_d = S_PAUSE;
`else
                        state_d = S_FETCH;
`endif
                    end
                end
            end
`ifdef FETCH_STEP_EN
            S_PAUSE: begin
                if (Stop) begin
                    state_d = S_HALT;
                end else if (step_rise) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // The RAM read is launched on the edge entering FETCH using the next PC,
    // so the word is ready during FETCH and lands in DIN as ISSUE begins.
    // Writes are held off while busy and on the accepted-Start cycle, which
    // already reads word 0, so a write never coincides with a read.
    prog_ram #(
        .AW (AW),
        .DW (DW)
    ) u_prog_ram (
        .Clock   (Clock),
        .wr_en   (ProgWr && !busy && !start_ok),
        .wr_addr (ProgAddr),
        .wr_data (ProgData),
        .rd_en   (state_d == S_FETCH),
        .rd_addr (pc_d),
        .rd_data (rd_data)
    );

    // Sequencer state, PC, retire counter and the DIN/Run output registers.
    // NOTE: synchronous active-low reset; state registers use non-blocking assignments.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= S_IDLE;
            pc          <= '0;
            last_addr   <= '0;
            instr_count <= '0;
            din         <= '0;
            run         <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            run   <= (state == S_FETCH);
            if (state == S_FETCH) begin
                din <= rd_data;
            end
            if (start_ok) begin
                last_addr   <= LastAddr;
                instr_count <= '0;
                halted      <= 1'b0;
            end else if (retire && (instr_count != 16'hFFFF)) begin
                instr_count <= instr_count + 16'd1;
            end
            if (halt_entry) begin
                halted <= 1'b1;
            end
        end
    end

    assign DIN        = din;
    assign Run        = run;
    assign Busy       = busy;
    assign Halted     = halted;
    assign PC         = pc;
    assign InstrCount = instr_count;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq. A tiny model of proc register r0
// tracks the issued immediate instructions; Done is driven by the bench.
// Step-mode checks are compiled in when FETCH_STEP_EN is defined.
module tb_instr_fetch_seq;

    import fetch_pkg::*;

    localparam int AW = 5;

    logic          Clock;
    logic          Resetn;
    logic          Start;
    logic          Stop;
    logic [AW-1:0] LastAddr;
    logic          ProgWr;
    logic [AW-1:0] ProgAddr;
    logic [15:0]   ProgData;
    logic          Done;
    logic          Step;
    logic [15:0]   DIN;
    logic          Run;
    logic          Busy;
    logic          Halted;
    logic [AW-1:0] PC;
    logic [15:0]   InstrCount;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int last_run = 0;
    int prev_run = 0;
    int gap;
    logic [15:0] r0;
    logic auto_step = 1'b1;

    instr_fetch_seq #(.AW(AW), .DW(16)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .Stop       (Stop),
        .LastAddr   (LastAddr),
        .ProgWr     (ProgWr),
        .ProgAddr   (ProgAddr),
        .ProgData   (ProgData),
        .Done       (Done),
`ifdef FETCH_STEP_EN
        .Step       (Step),
`endif
        .DIN        (DIN),
        .Run        (Run),
        .Busy       (Busy),
        .Halted     (Halted),
        .PC         (PC),
        .InstrCount (InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge Clock);
        #1;
        cyc_n++;
    endtask

    task automatic prog_write(input int addr, input int data);
        ProgWr   = 1'b1;
        ProgAddr = AW'(addr);
        ProgData = 16'(data);
        cyc();
        ProgWr   = 1'b0;
    endtask

    task automatic start_prog(input int la);
        LastAddr = AW'(la);
        Start    = 1'b1;
        cyc();
        Start    = 1'b0;
        r0       = 16'h0000;
    endtask

    // proc r0 model for immediate-form instructions targeting r0.
    task automatic proc_model(input logic [15:0] ir);
        if (ir[12] && ir[11:9] == 3'd0) begin
            case (ir[15:13])
                OP_MV:   r0 = {7'd0, ir[8:0]};
                OP_MVT:  r0 = {ir[7:0], 8'h00};
                OP_ADD:  r0 = r0 + {7'd0, ir[8:0]};
                OP_SUB:  r0 = r0 - {7'd0, ir[8:0]};
                default: r0 = r0;
            endcase
        end
    endtask

    // Wait (bounded) for the next Run, check the issued word, then retire it
    // with Done high d cycles after ISSUE, optionally holding Stop in WAIT.
    task automatic exec_one(input string tag, input int d, input logic stop_it, input int exp_din);
        int waited = 0;
        while (Run !== 1'b1 && waited < 40) begin
`ifdef FETCH_STEP_EN
            if (auto_step) Step = ~Step;
`endif
            cyc();
            waited++;
        end
        if (auto_step) Step = 1'b0;
        check({tag, "_run_seen"}, 32'(Run), 1);
        check({tag, "_din"}, 32'(DIN), exp_din);
        proc_model(DIN);
        prev_run = last_run;
        last_run = cyc_n;
        Stop = stop_it;
        for (int k = 1; k <= d; k++) begin
            cyc();
            if (k == 1) check({tag, "_run_single"}, 32'(Run), 0);
            if (k == d) Done = 1'b1;
        end
        cyc();
        Done = 1'b0;
        Stop = 1'b0;
    endtask

    initial begin
        Resetn   = 1'b0;
        Start    = 1'b0;
        Stop     = 1'b0;
        LastAddr = '0;
        ProgWr   = 1'b0;
        ProgAddr = '0;
        ProgData = '0;
        Done     = 1'b0;
        Step     = 1'b0;
        r0       = 16'h0000;

        // 1. Reset for two cycles, then Done pulses in IDLE must be ignored.
        cyc();
        cyc();
        check("rst_din", 32'(DIN), 0);
        check("rst_run", 32'(Run), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_halted", 32'(Halted), 0);
        check("rst_pc", 32'(PC), 0);
        check("rst_count", 32'(InstrCount), 0);
        Resetn = 1'b1;
        cyc();
        Done = 1'b1;
        cyc();
        cyc();
        Done = 1'b0;
        cyc();
        check("idle_done_busy", 32'(Busy), 0);
        check("idle_done_run", 32'(Run), 0);
        check("idle_done_count", 32'(InstrCount), 0);

        // 2. Two-word program: mv r0,#5 ; add r0,#3.
        prog_write(0, 32'h1005);
        prog_write(1, 32'h5003);
        start_prog(1);
        check("start_busy", 32'(Busy), 1);
        exec_one("p2_i0", 1, 1'b0, 32'h1005);
        exec_one("p2_i1", 1, 1'b0, 32'h5003);
        check("p2_r0", 32'(r0), 8);
        check("p2_halted", 32'(Halted), 1);
        check("p2_pc", 32'(PC), 1);
        check("p2_count", 32'(InstrCount), 2);
        check("p2_busy", 32'(Busy), 0);

        // 3. Done latency 1 then 3 gives issue gaps of 3 then 5.
        prog_write(2, 32'h7001);
        start_prog(2);
        exec_one("p3_i0", 1, 1'b0, 32'h1005);
        exec_one("p3_i1", 3, 1'b0, 32'h5003);
`ifndef FETCH_STEP_EN
        gap = last_run - prev_run;
        check("p3_gap_mv", 32'(gap), 3);
`endif
        exec_one("p3_i2", 1, 1'b0, 32'h7001);
`ifndef FETCH_STEP_EN
        gap = last_run - prev_run;
        check("p3_gap_add", 32'(gap), 5);
`endif
        check("p3_r0", 32'(r0), 7);
        check("p3_pc", 32'(PC), 2);
        check("p3_count", 32'(InstrCount), 3);

        // 4. Stop during the 2nd of 4 instructions, then restart from 0.
        prog_write(3, 32'h5002);
        start_prog(3);
        exec_one("p4_i0", 1, 1'b0, 32'h1005);
        exec_one("p4_i1", 2, 1'b1, 32'h5003);
        check("p4_stop_halted", 32'(Halted), 1);
        check("p4_stop_pc", 32'(PC), 1);
        check("p4_stop_count", 32'(InstrCount), 2);
        start_prog(3);
        check("p4_restart_pc", 32'(PC), 0);
        check("p4_restart_count", 32'(InstrCount), 0);
        check("p4_restart_halted", 32'(Halted), 0);

        // 5. Write to word 3 while busy is suppressed.
        prog_write(3, 32'hFFFF);
        exec_one("p5_i0", 1, 1'b0, 32'h1005);
        exec_one("p5_i1", 1, 1'b0, 32'h5003);
        exec_one("p5_i2", 1, 1'b0, 32'h7001);
        exec_one("p5_i3", 1, 1'b0, 32'h5002);
        check("p5_r0", 32'(r0), 9);
        check("p5_count", 32'(InstrCount), 4);
        check("p5_pc", 32'(PC), 3);

        // 5b. The same write while halted takes effect.
        prog_write(3, 32'h5007);
        start_prog(3);
        exec_one("p5b_i0", 1, 1'b0, 32'h1005);
        exec_one("p5b_i1", 1, 1'b0, 32'h5003);
        exec_one("p5b_i2", 1, 1'b0, 32'h7001);
        exec_one("p5b_i3", 1, 1'b0, 32'h5007);
        check("p5b_r0", 32'(r0), 14);

        // 5c. Reset while waiting for Done.
        start_prog(3);
        for (int i = 0; i < 40 && Run !== 1'b1; i++) cyc();
        check("p5c_run_seen", 32'(Run), 1);
        cyc();
        check("p5c_in_wait_busy", 32'(Busy), 1);
        Resetn = 1'b0;
        cyc();
        check("p5c_rst_run", 32'(Run), 0);
        check("p5c_rst_busy", 32'(Busy), 0);
        check("p5c_rst_pc", 32'(PC), 0);
        check("p5c_rst_din", 32'(DIN), 0);
        check("p5c_rst_count", 32'(InstrCount), 0);
        Resetn = 1'b1;
        cyc();

        // No PC wrap: 32 words with LastAddr=31 halt at PC=31.
        for (int i = 0; i < 32; i++) prog_write(i, 32'h1000 | i);
        start_prog(31);
        for (int i = 0; i < 32; i++) exec_one($sformatf("wrap_i%0d", i), 1, 1'b0, 32'h1000 | i);
        check("wrap_halted", 32'(Halted), 1);
        check("wrap_pc", 32'(PC), 31);
        check("wrap_count", 32'(InstrCount), 32);
        cyc();
        cyc();
        check("wrap_no_run", 32'(Run), 0);
        check("wrap_busy", 32'(Busy), 0);

`ifdef FETCH_STEP_EN
        // 6. Single-step: PAUSE after each retire, one issue per Step rise.
        auto_step = 1'b0;
        Step = 1'b0;
        prog_write(0, 32'h1005);
        prog_write(1, 32'h5003);
        prog_write(2, 32'h7001);
        prog_write(3, 32'h5002);
        start_prog(3);
        exec_one("st_i0", 1, 1'b0, 32'h1005);
        cyc();
        cyc();
        cyc();
        check("st_pause_run", 32'(Run), 0);
        check("st_pause_busy", 32'(Busy), 1);
        check("st_pause_pc", 32'(PC), 1);
        Step = 1'b1;
        exec_one("st_i1", 1, 1'b0, 32'h5003);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("st_hold_run", 32'(Run), 0);
        end
        check("st_hold_busy", 32'(Busy), 1);
        check("st_hold_pc", 32'(PC), 2);
        Step = 1'b0;
        cyc();
        Step = 1'b1;
        exec_one("st_i2", 1, 1'b0, 32'h7001);
        Step = 1'b0;
        Stop = 1'b1;
        cyc();
        Stop = 1'b0;
        check("st_stop_halted", 32'(Halted), 1);
        check("st_stop_busy", 32'(Busy), 0);
        check("st_stop_pc", 32'(PC), 3);
        check("st_stop_count", 32'(InstrCount), 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
